// File: rtl/prog_mem_controller.sv
// prog_mem_controller
//
// Shares NUM_CHANNELS program-memory read channels among NUM_CONSUMERS
// instruction fetchers. Idle channels grant pending fetchers in round-robin
// order, relay the read to memory, and hand the returned word back to the
// fetcher that asked for it.
//
// Handshakes (both sides are level-based, sampled on the rising clk edge):
//   Fetcher side: a fetcher raises consumer_read_valid with its address and
//   holds it; the controller raises consumer_read_ready together with the
//   data and keeps it up until it samples consumer_read_valid low, which
//   completes the transfer and frees the fetcher for a new grant.
//   Memory side: a channel holds mem_read_valid and mem_read_address stable
//   while WAITING; the first sampled mem_read_ready for that channel
//   completes the read and drops mem_read_valid. mem_read_ready in any other
//   state is ignored.
//
// Ports:
//   clk, reset               - clock; asynchronous active-high reset
//   consumer_read_valid      - per-fetcher request (level)
//   consumer_read_address    - packed per-fetcher addresses
//   consumer_read_ready      - per-fetcher data-valid acknowledge
//   consumer_read_data       - packed per-fetcher data (held until next relay)
//   mem_read_valid           - per-channel memory request
//   mem_read_address         - packed per-channel addresses
//   mem_read_ready           - per-channel memory data valid
//   mem_read_data            - packed per-channel memory data
//   channel_state            - packed per-channel FSM state (2 bits each)

module prog_mem_controller #(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS*2-1:0]          channel_state
);

    localparam int CW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAITING  = 2'd1,
        ST_RELAYING = 2'd2
    } state_t;

    state_t                 state_q   [NUM_CHANNELS];
    state_t                 state_d   [NUM_CHANNELS];
    logic [CW-1:0]          ch_cons   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   ch_addr   [NUM_CHANNELS];
    logic [CW-1:0]          grant_idx [NUM_CHANNELS];

    logic [NUM_CONSUMERS-1:0] serving;
    logic [NUM_CONSUMERS-1:0] pending;
    logic [NUM_CONSUMERS-1:0] granted;
    logic [CW-1:0]            rr_ptr;
    logic [CW-1:0]            rr_next;
    logic [NUM_CHANNELS-1:0]  grant_valid;
    logic [NUM_CHANNELS-1:0]  do_relay;
    logic [NUM_CHANNELS-1:0]  do_release;

    // Arbiter: idle channels, lowest index first, each take the next pending
    // fetcher searching cyclically from rr_ptr. 'granted' keeps two channels
    // from picking the same fetcher in one cycle. The pointer follows the
    // last grant made, so the fetcher after it has top priority next time.
    always_comb begin
        logic [CW-1:0] cand_idx;
        cand_idx    = '0;
        pending     = consumer_read_valid & ~serving;
        granted     = '0;
        grant_valid = '0;
        rr_next     = rr_ptr;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            grant_idx[c] = '0;
            if (state_q[c] == ST_IDLE) begin
                for (int j = 0; j < NUM_CONSUMERS; j++) begin
                    cand_idx = CW'((int'(rr_ptr) + j) % NUM_CONSUMERS);
                    if (!grant_valid[c] && pending[cand_idx] && !granted[cand_idx]) begin
                        grant_valid[c]    = 1'b1;
                        grant_idx[c]      = cand_idx;
                        granted[cand_idx] = 1'b1;
                        rr_next           = CW'((int'(cand_idx) + 1) % NUM_CONSUMERS);
                    end
                end
            end
        end
    end

    // Channel FSM next state. A fetcher that drops valid while its read is
    // still WAITING is only noticed once the channel is RELAYING, so the
    // read always completes and ready is shown for at least one cycle.
    always_comb begin
        do_relay   = '0;
        do_release = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            state_d[c] = state_q[c];
            case (state_q[c])
                ST_IDLE: begin
                    if (grant_valid[c]) state_d[c] = ST_WAITING;
                end
                ST_WAITING: begin
                    if (mem_read_ready[c]) begin
                        state_d[c]  = ST_RELAYING;
                        do_relay[c] = 1'b1;
                    end
                end
                ST_RELAYING: begin
                    if (!consumer_read_valid[ch_cons[c]]) begin
                        state_d[c]    = ST_IDLE;
                        do_release[c] = 1'b1;
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) state_q[c] <= ST_IDLE;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) state_q[c] <= state_d[c];
        end
    end

    // Per-channel latches and per-fetcher outputs. A fetcher is marked
    // serving from grant to release, so it cannot be re-granted before the
    // edge after its release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr              <= '0;
            serving             <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                ch_cons[c] <= '0;
                ch_addr[c] <= '0;
            end
        end else begin
            rr_ptr <= rr_next;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (grant_valid[c]) begin
                    ch_cons[c]            <= grant_idx[c];
                    ch_addr[c]            <= consumer_read_address[grant_idx[c]*ADDR_BITS +: ADDR_BITS];
                    serving[grant_idx[c]] <= 1'b1;
                end
                if (do_relay[c]) begin
                    consumer_read_data[ch_cons[c]*DATA_BITS +: DATA_BITS] <= mem_read_data[c*DATA_BITS +: DATA_BITS];
                    consumer_read_ready[ch_cons[c]] <= 1'b1;
                end
                if (do_release[c]) begin
                    consumer_read_ready[ch_cons[c]] <= 1'b0;
                    serving[ch_cons[c]]             <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        mem_read_valid   = '0;
        mem_read_address = '0;
        channel_state    = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            mem_read_valid[c]                          = (state_q[c] == ST_WAITING);
            mem_read_address[c*ADDR_BITS +: ADDR_BITS] = ch_addr[c];
            channel_state[c*2 +: 2]                    = state_q[c];
        end
    end

endmodule

// File: tb/tb_prog_mem_controller.sv
// Bench for prog_mem_controller: one single-channel and one dual-channel
// instance share clock and reset. Directed steps with random addresses,
// random memory contents and random request subsets; expected grants come
// from a plain round-robin model and expected data from a memory array.

module tb_prog_mem_controller;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // single-channel instance (a)
  logic [3:0]  c_valid;
  logic [31:0] c_addr;
  logic [3:0]  c_ready;
  logic [63:0] c_data;
  logic [0:0]  m_valid;
  logic [7:0]  m_addr;
  logic [0:0]  m_ready;
  logic [15:0] m_data;
  logic [1:0]  dbg_a;

  // dual-channel instance (b)
  logic [3:0]  d_valid;
  logic [31:0] d_addr;
  logic [3:0]  d_ready;
  logic [63:0] d_data;
  logic [1:0]  n_valid;
  logic [15:0] n_addr;
  logic [1:0]  n_ready;
  logic [31:0] n_data;
  logic [3:0]  dbg_b;

  prog_mem_controller #(.NUM_CONSUMERS(4), .NUM_CHANNELS(1), .ADDR_BITS(8), .DATA_BITS(16)) dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c_valid), .consumer_read_address(c_addr),
    .consumer_read_ready(c_ready), .consumer_read_data(c_data),
    .mem_read_valid(m_valid), .mem_read_address(m_addr),
    .mem_read_ready(m_ready), .mem_read_data(m_data),
    .channel_state(dbg_a)
  );

  prog_mem_controller #(.NUM_CONSUMERS(4), .NUM_CHANNELS(2), .ADDR_BITS(8), .DATA_BITS(16)) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(d_valid), .consumer_read_address(d_addr),
    .consumer_read_ready(d_ready), .consumer_read_data(d_data),
    .mem_read_valid(n_valid), .mem_read_address(n_addr),
    .mem_read_ready(n_ready), .mem_read_data(n_data),
    .channel_state(dbg_b)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [15:0] mem_model [256];
  int ptr_a;
  int ptr_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin reference: first requester at or after ptr, cyclically.
  function automatic int rr_pick(input logic [3:0] pend, input int ptr);
    for (int j = 0; j < 4; j++) begin
      int k;
      k = (ptr + j) % 4;
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  // Random address whose low two bits name the consumer, so the address
  // seen on the memory port identifies which consumer was granted.
  function automatic logic [7:0] uaddr(input int i);
    logic [5:0] r;
    r = 6'($urandom);
    return {r, 2'(i)};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
    reset = 1'b1;
    c_valid = '0; c_addr = '0; m_ready = '0; m_data = '0;
    d_valid = '0; d_addr = '0; n_ready = '0; n_data = '0;
    tick();
    tick();

    // ---- reset state
    chk("rst_c_ready", 64'(c_ready), 64'd0);
    chk("rst_c_data", c_data, 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_addr", 64'(m_addr), 64'd0);
    chk("rst_state_a", 64'(dbg_a), 64'd0);
    chk("rst_n_valid", 64'(n_valid), 64'd0);
    chk("rst_state_b", 64'(dbg_b), 64'd0);
    reset = 1'b0;
    ptr_a = 0;
    ptr_b = 0;

    // ---- single fetch: consumer 2, addr 0x1A, data 0xBEEF
    c_valid = 4'b0100;
    c_addr[23:16] = 8'h1A;
    tick();
    chk("sf_mem_valid", 64'(m_valid), 64'd1);
    chk("sf_mem_addr", 64'(m_addr), 64'h1A);
    chk("sf_no_ready", 64'(c_ready), 64'd0);
    m_ready = 1'b1;
    m_data = 16'hBEEF;
    tick();
    chk("sf_ready", 64'(c_ready), 64'b0100);
    chk("sf_data", 64'(c_data[47:32]), 64'hBEEF);
    chk("sf_mem_valid_low", 64'(m_valid), 64'd0);
    m_ready = 1'b0;
    c_valid = '0;
    tick();
    chk("sf_release", 64'(c_ready), 64'd0);
    chk("sf_idle", 64'(dbg_a), 64'd0);
    chk("sf_data_hold", 64'(c_data[47:32]), 64'hBEEF);

    // ---- round robin on one channel, everyone re-requests at once
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ptr_a = 0;
    for (int i = 0; i < 4; i++) c_addr[i*8 +: 8] = uaddr(i);
    c_valid = 4'hF;
    for (int t = 0; t < 6; t++) begin
      int exp_c;
      logic [7:0] a;
      exp_c = rr_pick(4'hF, ptr_a);
      a = c_addr[exp_c*8 +: 8];
      tick();
      chk("rr_grant", 64'(m_addr), 64'(a));
      m_ready = 1'b1;
      m_data = mem_model[a];
      tick();
      chk("rr_ready", 64'(c_ready), 64'(4'b1 << exp_c));
      chk("rr_data", 64'(c_data[exp_c*16 +: 16]), 64'(mem_model[a]));
      m_ready = 1'b0;
      c_valid[exp_c] = 1'b0;
      tick();
      chk("rr_release", 64'(c_ready), 64'd0);
      c_valid[exp_c] = 1'b1;
      c_addr[exp_c*8 +: 8] = uaddr(exp_c);
      ptr_a = (exp_c + 1) % 4;
    end
    c_valid = '0;

    // ---- memory stall for 10 cycles, fetcher address changes meanwhile
    begin
      int k;
      logic [7:0] a;
      k = int'($urandom_range(0, 3));
      a = uaddr(k);
      c_addr[k*8 +: 8] = a;
      c_valid = 4'(1 << k);
      tick();
      chk("stall_grant", 64'(m_addr), 64'(a));
      c_addr[k*8 +: 8] = ~a;
      for (int s = 0; s < 10; s++) begin
        tick();
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_addr", 64'(m_addr), 64'(a));
        chk("stall_no_ready", 64'(c_ready), 64'd0);
      end
      m_ready = 1'b1;
      m_data = mem_model[a];
      tick();
      chk("stall_ready", 64'(c_ready), 64'(4'b1 << k));
      chk("stall_data", 64'(c_data[k*16 +: 16]), 64'(mem_model[a]));
      m_ready = 1'b0;
      c_valid = '0;
      tick();
      chk("stall_release", 64'(c_ready), 64'd0);
    end

    // ---- reset while WAITING, then a stray memory ready
    c_addr[15:8] = uaddr(1);
    c_valid = 4'b0010;
    tick();
    chk("rm_waiting", 64'(m_valid), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("rm_m_valid", 64'(m_valid), 64'd0);
    chk("rm_m_addr", 64'(m_addr), 64'd0);
    chk("rm_c_ready", 64'(c_ready), 64'd0);
    chk("rm_c_data", c_data, 64'd0);
    chk("rm_state", 64'(dbg_a), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    c_valid = '0;
    m_ready = 1'b1;
    m_data = 16'($urandom);
    tick();
    chk("rm_stray_ready", 64'(c_ready), 64'd0);
    chk("rm_stray_data", c_data, 64'd0);
    chk("rm_stray_state", 64'(dbg_a), 64'd0);
    m_ready = 1'b0;
    c_addr[7:0] = uaddr(0);
    c_addr[23:16] = uaddr(2);
    c_valid = 4'b0101;
    tick();
    chk("rm_search_from0", 64'(m_addr), 64'(c_addr[7:0]));
    m_ready = 1'b1;
    m_data = mem_model[c_addr[7:0]];
    tick();
    chk("rm_next_ready", 64'(c_ready), 64'b0001);
    m_ready = 1'b0;
    c_valid[0] = 1'b0;
    tick();
    c_valid = '0;
    chk("rm_next_release", 64'(c_ready), 64'd0);

    // ---- late drop of valid during WAITING
    begin
      int k;
      logic [7:0] a;
      k = int'($urandom_range(0, 3));
      a = uaddr(k);
      c_addr[k*8 +: 8] = a;
      tick();
      c_valid = 4'(1 << k);
      tick();
      chk("ld_grant", 64'(m_valid), 64'd1);
      c_valid = '0;
      tick();
      chk("ld_still_waiting", 64'(m_valid), 64'd1);
      chk("ld_state_waiting", 64'(dbg_a), 64'd1);
      m_ready = 1'b1;
      m_data = mem_model[a];
      tick();
      chk("ld_ready", 64'(c_ready), 64'(4'b1 << k));
      chk("ld_data", 64'(c_data[k*16 +: 16]), 64'(mem_model[a]));
      m_ready = 1'b0;
      tick();
      chk("ld_ready_1cyc", 64'(c_ready), 64'd0);
      chk("ld_idle", 64'(dbg_a), 64'd0);
    end

    // ---- two channels, consumers 1 and 3 on the same edge
    begin
      logic [7:0] a1, a3;
      a1 = uaddr(1);
      a3 = uaddr(3);
      d_addr[15:8] = a1;
      d_addr[31:24] = a3;
      d_valid = 4'b1010;
      tick();
      chk("dc_valid", 64'(n_valid), 64'b11);
      chk("dc_addr0", 64'(n_addr[7:0]), 64'(a1));
      chk("dc_addr1", 64'(n_addr[15:8]), 64'(a3));
      n_ready = 2'b11;
      n_data = {16'hB333, 16'hA111};
      tick();
      chk("dc_ready", 64'(d_ready), 64'b1010);
      chk("dc_data1", 64'(d_data[31:16]), 64'hA111);
      chk("dc_data3", 64'(d_data[63:48]), 64'hB333);
      chk("dc_others", 64'({d_data[47:32], d_data[15:0]}), 64'd0);
      n_ready = '0;
      d_valid = '0;
      tick();
      chk("dc_release", 64'(d_ready), 64'd0);
      chk("dc_idle", 64'(dbg_b), 64'd0);
      ptr_b = 0;
    end

    // ---- random request subsets on two channels; memory ready held high
    //      on both channels so an idle channel sees a spurious ready
    for (int r = 0; r < 12; r++) begin
      logic [3:0] subset, exp_r;
      int g0, g1, last;
      logic [7:0] a0, a1;
      subset = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) d_addr[i*8 +: 8] = uaddr(i);
      g0 = rr_pick(subset, ptr_b);
      g1 = rr_pick(subset & ~(4'b1 << g0), ptr_b);
      a0 = d_addr[g0*8 +: 8];
      a1 = 8'd0;
      exp_r = 4'b1 << g0;
      last = g0;
      if (g1 >= 0) begin
        a1 = d_addr[g1*8 +: 8];
        exp_r = exp_r | (4'b1 << g1);
        last = g1;
      end
      d_valid = subset;
      tick();
      chk("rnd_valid", 64'(n_valid), 64'({g1 >= 0, 1'b1}));
      chk("rnd_addr0", 64'(n_addr[7:0]), 64'(a0));
      if (g1 >= 0) chk("rnd_addr1", 64'(n_addr[15:8]), 64'(a1));
      n_ready = 2'b11;
      n_data = {mem_model[a1], mem_model[a0]};
      tick();
      chk("rnd_ready", 64'(d_ready), 64'(exp_r));
      chk("rnd_data0", 64'(d_data[g0*16 +: 16]), 64'(mem_model[a0]));
      if (g1 >= 0) chk("rnd_data1", 64'(d_data[g1*16 +: 16]), 64'(mem_model[a1]));
      n_ready = '0;
      d_valid = '0;
      tick();
      chk("rnd_release", 64'(d_ready), 64'd0);
      ptr_b = (last + 1) % 4;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_mem_controller.md
# prog_mem_controller

Read-only arbiter that shares a small number of program-memory read channels among the per-core fetchers. Each fetcher presents a level request with an address. The controller grants requests to free channels in round-robin order and relays each memory read to the memory. It then returns the data to the fetcher with a ready/acknowledge handshake. It sits between the array of core fetchers and the external program-memory port.

## Interface
- `NUM_CONSUMERS`, default 4: number of fetchers served (≥1).
- `NUM_CHANNELS`, default 1: number of concurrent program-memory read channels (1..`NUM_CONSUMERS`).
- `ADDR_BITS`, default 8: address width.
- `DATA_BITS`, default 16: instruction word width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `consumer_read_valid` in `NUM_CONSUMERS`: per-fetcher read request (level).
- `consumer_read_address` in `NUM_CONSUMERS*ADDR_BITS`: packed addresses; consumer i occupies bits `[i*ADDR_BITS +: ADDR_BITS]`.
- `consumer_read_ready` out `NUM_CONSUMERS`: per-fetcher data-valid acknowledge.
- `consumer_read_data` out `NUM_CONSUMERS*DATA_BITS`: packed data, same packing as addresses.
- `mem_read_valid` out `NUM_CHANNELS`: per-channel memory request.
- `mem_read_address` out `NUM_CHANNELS*ADDR_BITS`: packed channel addresses.
- `mem_read_ready` in `NUM_CHANNELS`: memory data valid for that channel.
- `mem_read_data` in `NUM_CHANNELS*DATA_BITS`: packed memory data.

## Operation
- **Per-channel FSM:**
  - `IDLE` → `WAITING`: on grant. Latches the consumer index and address; asserts `mem_read_valid`.
  - `WAITING` → `RELAYING`: on `mem_read_ready`. Deasserts `mem_read_valid`; latches data into that consumer's `consumer_read_data`; asserts its `consumer_read_ready`.
  - `RELAYING` → `IDLE`: when that consumer's `consumer_read_valid` is sampled low. Deasserts `consumer_read_ready` and frees the consumer.
- **Busy mask:** `serving[i]` is set from grant until the `RELAYING` release. A consumer is pending when `valid & ~serving`.
- **Arbitration (per cycle):**
  - Among `IDLE` channels, taken in ascending index, each channel grants the next pending consumer.
  - The search is cyclic, starting at `rr_ptr` and skipping consumers already granted this cycle.
  - No consumer is ever granted to two channels.
  - `rr_ptr` advances to (last granted index + 1) mod `NUM_CONSUMERS`. It is unchanged if nothing is granted.
- **Ordering:** a released consumer can be regranted no earlier than the edge after its release.
- **Address/data:**
  - Address and data pass through unmodified; no width conversion.
  - `consumer_read_data` holds its value after ready drops, until the next relay to that consumer.
- **Late request drop:** deassertion of `consumer_read_valid` during `WAITING` is ignored. The read completes, and the channel then releases on the first low sample in `RELAYING`.

## Timing
- **Reset values:** all outputs 0 (`mem_read_valid`, `mem_read_address`, `consumer_read_ready`, `consumer_read_data`); every channel `IDLE`; `serving`=0; `rr_ptr`=0.
- **Reset mid-operation:** in-flight reads are abandoned; a `mem_read_ready` arriving after reset is ignored.
- **Per-transaction edges:**
  - Valid seen at edge E → `mem_read_valid` high after E.
  - `mem_read_ready` seen at edge M → `consumer_read_ready` high after M.
  - Consumer valid low seen at edge R → ready low and channel `IDLE` after R.
- **Latency:** minimum request-to-data is 2 edges with single-cycle memory. Minimum back-to-back cycle per channel is 4 edges with a 1-cycle fetcher release.
- **Memory-side handshake:** `mem_read_ready` is only honoured in `WAITING`; a spurious ready in `IDLE` or `RELAYING` is ignored. Memory is expected to drop ready once valid falls.
- **Fetcher interaction:** a fetcher holding valid high indefinitely holds its channel in `RELAYING`; this is permitted and not a deadlock for other channels.

## Test plan
- **Single fetch:**
  - Stimulus: consumer 2 requests addr 0x1A; memory returns 0xBEEF one cycle after valid.
  - Response: `mem_read_address`=0x1A; consumer 2 gets ready with data 0xBEEF. Ready drops one edge after valid falls; channel returns to `IDLE`.
- **Round-robin, one channel:**
  - Stimulus: all 4 consumers request simultaneously and re-request immediately.
  - Response: grant order 0,1,2,3,0. No consumer is served twice before all others are served once.
- **Two channels, same edge:**
  - Stimulus: `NUM_CHANNELS`=2; consumers 1 and 3 request together.
  - Response: channel 0 serves 1 and channel 1 serves 3 on the same edge. Each consumer receives only its own data.
- **Memory stall:**
  - Stimulus: memory holds ready low for 10 cycles.
  - Response: `mem_read_valid` stays high with a stable address; no consumer ready appears until the memory ready.
- **Reset mid-read:**
  - Stimulus: assert reset asynchronously while in `WAITING`, then pulse `mem_read_ready`.
  - Response: all outputs 0 immediately, no data relayed; the next request is granted to consumer 0 search order.
- **Late drop of valid:**
  - Stimulus: consumer drops valid during `WAITING`.
  - Response: data is still relayed with ready for exactly 1 cycle, then the channel returns to `IDLE`.
